mix_columns_engine: RTL and testbench
=====================================

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 The block SHALL have parameter COLS_PER_CYCLE, default 1, giving the state columns processed per cycle; legal values are 1, 2 and 4.
REQ-002 Port clk  input  1  is the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst  input  1  is the reset: synchronous, active-high.
REQ-004 Port in_valid  input  1  SHALL indicate that in_state and in_skip are valid.
REQ-005 Port in_ready  output  1  SHALL be high when a new state can be accepted.
REQ-006 Port in_state  input  128  is the AES state: column c is [127-32c:96-32c], and row 0 is the MSB byte of each column.
REQ-007 Port in_skip  input  1  SHALL, when high, make the block pass the state through unchanged (final AES round).
REQ-008 Port out_valid  output  1  SHALL be high when out_state holds a result.
REQ-009 Port out_ready  input  1  SHALL indicate that the downstream block accepts out_state.
REQ-010 Port out_state  output  128  is the forward-MixColumns result, using the same layout as in_state.

Function
REQ-011 The block SHALL compute forward MixColumns over GF(2^8) with polynomial 0x11B; per column [a0..a3], r0=2a0^3a1^a2^a3, r1=a0^2a1^3a2^a3, r2=a0^a1^2a2^3a3, r3=3a0^a1^a2^2a3.
REQ-012 The block SHALL implement multiplication by 2 as xtime (shift left, then XOR 0x1B if bit 7 was set); multiplication by 3 SHALL be xtime(x)^x; no lookup tables SHALL be used.
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 In IDLE, in_ready=1; a transfer (in_valid&&in_ready) SHALL register in_state and in_skip, clear the column counter and move to BUSY.
REQ-015 In BUSY, each cycle SHALL transform COLS_PER_CYCLE columns, in order starting at column 0, and write them into the result register.
REQ-016 The column counter SHALL advance by COLS_PER_CYCLE and wrap at 4; when the last group is written, the FSM SHALL move to DONE.
REQ-017 If the latched skip is 1, BUSY SHALL copy the columns unchanged, with the same cycle timing.
REQ-018 Latency SHALL be 4/COLS_PER_CYCLE cycles in BUSY, so out_valid rises on the cycle after the last group is written (cycle 5 after acceptance for COLS_PER_CYCLE=1).
REQ-019 In DONE, out_valid=1 and out_state SHALL stay stable until out_ready is sampled high.
REQ-020 When DONE sees out_ready=1 and in_valid=1 in the same cycle, the block SHALL complete the output transfer and accept the new input in that cycle (in_ready=out_ready in DONE), then go to BUSY.
REQ-021 When DONE sees out_ready=1 and in_valid=0, the FSM SHALL go to IDLE.
REQ-022 in_ready SHALL be 0 throughout BUSY, and inputs presented then SHALL be ignored.
REQ-023 out_valid SHALL be 0 in IDLE and BUSY.

Reset
REQ-024 When rst=1 at a clock edge, the FSM SHALL go to IDLE and the counter, result register, latched skip and out_state SHALL be cleared to 0.
REQ-025 The reset values SHALL be out_valid=0, in_ready=1 and out_state=128'h0.
REQ-026 A reset asserted during BUSY or DONE SHALL abort the operation with no output transfer; the first cycle after reset SHALL accept input.

Structure
REQ-027 A shared package aes_pkg SHALL hold the xtime function, the state_t (128-bit) and col_t (32-bit) typedefs, and the constant AES_POLY=8'h1B.
REQ-028 The single column transform SHALL be a combinational sub-module mix_column_fwd (32-bit in, 32-bit out), instantiated COLS_PER_CYCLE times.

Verification
REQ-029 COLS_PER_CYCLE=1, in_state=db135345_f20a225c_01010101_c6c6c6c6, skip=0 -> out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid rising 5 cycles after acceptance.
REQ-030 in_state=d4d4d4d5_2d26314c_db135345_f20a225c -> out_state=d5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d, for each of COLS_PER_CYCLE=1, 2 and 4, with latency 4, 2 and 1 cycles respectively.
REQ-031 skip=1 with any state -> out_state equals in_state after the same latency.
REQ-032 out_ready held low for 10 cycles in DONE -> out_state is stable and in_ready=0; when out_ready rises with in_valid=1, the result is transferred and the new input is accepted in the same cycle (back-to-back throughput).
REQ-033 rst pulsed in the middle of BUSY -> out_valid=0, out_state=0 and in_ready=1 on the next cycle, and the next state processes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, field constant, FSM encoding and xtime helper
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_fsm_e;

  // Multiply by 2 in GF(2^8): shift left, fold bit 7 back through the field polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_fwd.sv
// rtl/mix_column_fwd.sv - combinational forward MixColumns of one 32-bit column
module mix_column_fwd
  import aes_pkg::*;
(
  input  col_t col_i,
  output col_t col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3*a is expressed as xtime(a)^a, so each row is a handful of XORs.
  assign col_o[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign col_o[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign col_o[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign col_o[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mix_columns_engine.sv
// rtl/mix_columns_engine.sv - iterative forward MixColumns engine with valid/ready handshakes
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t in_state,
  input  logic   in_skip,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t out_state
);

  // Counter step wraps to 0 for four columns per cycle, which is the single-group case.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  mc_fsm_e    state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       skip_q, skip_d;
  // Packed as [3:0] so column c lives at index 3-c, i.e. ~c.
  col_t [3:0] src_q, src_d;
  col_t [3:0] res_q, res_d;

  logic [1:0] col_idx [COLS_PER_CYCLE];
  col_t       col_src [COLS_PER_CYCLE];
  col_t       col_mix [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = cnt_q + 2'(g);
    assign col_src[g] = src_q[~col_idx[g]];

    mix_column_fwd u_mix (
      .col_i (col_src[g]),
      .col_o (col_mix[g])
    );
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    skip_d    = skip_q;
    src_d     = src_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          src_d   = in_state;
          skip_d  = in_skip;
          cnt_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          res_d[~col_idx[g]] = skip_q ? col_src[g] : col_mix[g];
        end
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Output drain and next input accept share the same cycle.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            src_d   = in_state;
            skip_d  = in_skip;
            cnt_d   = 2'd0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      skip_q  <= 1'b0;
      src_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      src_q   <= src_d;
      res_q   <= res_d;
    end
  end

  assign out_state = res_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb/tb_mix_columns_engine.sv - directed bench for mix_columns_engine at 1, 2 and 4 columns per cycle
module tb_mix_columns_engine;

  localparam logic [127:0] VEC1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VEC1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VEC2_IN  = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
  localparam logic [127:0] VEC2_OUT = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;
  localparam logic [127:0] VEC3_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   iv;
  logic [2:0]   ordy;
  logic [127:0] in_state;
  logic         in_skip;
  logic [2:0]   ov;
  logic [2:0]   ir;
  logic [127:0] os [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mix_columns_engine #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(in_state),
    .in_skip(in_skip), .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(os[0])
  );
  mix_columns_engine #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(in_state),
    .in_skip(in_skip), .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(os[1])
  );
  mix_columns_engine #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(in_state),
    .in_skip(in_skip), .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(os[2])
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Counts edges until out_valid rises, bounded so a stuck DUT still reaches the summary.
  task automatic wait_valid(input int sel, output int lat);
    lat = 0;
    while (ov[sel] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain(input int sel, input string tag);
    ordy[sel] = 1'b1;
    @(posedge clk); #1;
    ordy[sel] = 1'b0;
    check_eq({tag, " idle_valid"}, 128'(ov[sel]), 128'd0);
    check_eq({tag, " idle_ready"}, 128'(ir[sel]), 128'd1);
  endtask

  // One full transaction; garbage with in_valid high is presented while busy and must be ignored.
  task automatic run_txn(input int sel, input logic [127:0] st, input logic sk,
                         input logic [127:0] exp, input int exp_lat, input string tag);
    int lat;
    iv[sel]  = 1'b1;
    in_state = st;
    in_skip  = sk;
    @(posedge clk); #1;
    check_eq({tag, " busy_ready"}, 128'(ir[sel]), 128'd0);
    in_state = ~st;
    in_skip  = ~sk;
    wait_valid(sel, lat);
    iv[sel]  = 1'b0;
    check_eq({tag, " latency"}, 128'(lat), 128'(exp_lat));
    check_eq({tag, " result"}, os[sel], exp);
    drain(sel, tag);
  endtask

  initial begin
    int lat;
    rst      = 1'b1;
    iv       = '0;
    ordy     = '0;
    in_state = '0;
    in_skip  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("reset%0d out_valid", i), 128'(ov[i]), 128'd0);
      check_eq($sformatf("reset%0d in_ready", i), 128'(ir[i]), 128'd1);
      check_eq($sformatf("reset%0d out_state", i), os[i], 128'd0);
    end
    rst = 1'b0;

    run_txn(0, VEC1_IN, 1'b0, VEC1_OUT, 4, "c1 vec1");
    run_txn(0, VEC2_IN, 1'b0, VEC2_OUT, 4, "c1 vec2");
    run_txn(1, VEC2_IN, 1'b0, VEC2_OUT, 2, "c2 vec2");
    run_txn(2, VEC2_IN, 1'b0, VEC2_OUT, 1, "c4 vec2");
    run_txn(1, VEC1_IN, 1'b0, VEC1_OUT, 2, "c2 vec1");
    run_txn(0, VEC3_IN, 1'b1, VEC3_IN, 4, "c1 skip");
    run_txn(1, VEC3_IN, 1'b1, VEC3_IN, 2, "c2 skip");
    run_txn(2, VEC2_IN, 1'b1, VEC2_IN, 1, "c4 skip");

    // Backpressure in DONE, then back-to-back drain and accept.
    iv[0]    = 1'b1;
    in_state = VEC1_IN;
    in_skip  = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    wait_valid(0, lat);
    check_eq("bp latency", 128'(lat), 128'd4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("bp hold%0d state", i), os[0], VEC1_OUT);
      check_eq($sformatf("bp hold%0d ready", i), 128'(ir[0]), 128'd0);
    end
    check_eq("bp hold valid", 128'(ov[0]), 128'd1);
    ordy[0]  = 1'b1;
    iv[0]    = 1'b1;
    in_state = VEC2_IN;
    #1;
    check_eq("b2b in_ready", 128'(ir[0]), 128'd1);
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    iv[0]   = 1'b0;
    check_eq("b2b busy_valid", 128'(ov[0]), 128'd0);
    wait_valid(0, lat);
    check_eq("b2b latency", 128'(lat), 128'd4);
    check_eq("b2b result", os[0], VEC2_OUT);
    drain(0, "b2b");

    // Reset in the middle of BUSY.
    iv[0]    = 1'b1;
    in_state = VEC2_IN;
    in_skip  = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_busy out_valid", 128'(ov[0]), 128'd0);
    check_eq("rst_busy out_state", os[0], 128'd0);
    check_eq("rst_busy in_ready", 128'(ir[0]), 128'd1);
    run_txn(0, VEC1_IN, 1'b0, VEC1_OUT, 4, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
